// File: rtl/cp_insert_param.sv
// Cyclic-prefix inserter: ping-pong buffers one IFFT symbol, then streams the last NCP
// samples followed by the full symbol over a Wishbone-style streaming handshake.
module cp_insert_param #(
   parameter int unsigned NFFT_LOG2 = 8,
   parameter int unsigned DW        = 32
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I,
   input  logic          CYC_I,
   input  logic          STB_I,
   input  logic          WE_I,
   output logic          ACK_O,
   input  logic [1:0]    CP_SEL,
   output logic [DW-1:0] DAT_O,
   output logic          CYC_O,
   output logic          STB_O,
   output logic          WE_O,
   input  logic          ACK_I
);

   localparam int unsigned N  = 1 << NFFT_LOG2;
   localparam int unsigned AW = NFFT_LOG2;
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {RIdle, RCp, RBody} rstate_t;

   logic [DW-1:0] mem [2*N];

   logic [AW-1:0] wptr, rptr;
   logic          wbuf, rbuf;
   logic [1:0]    full;
   logic [1:0]    cp [2];
   rstate_t       state;

   logic [DW-1:0] rdata, skid_dat, dat;
   logic          rd_vld, skid_vld, stb, cyc;

   logic          ack, wr_last, rd_last, issue, pop, other_full, busy_next;
   logic [1:0]    occ;
   logic [DW-1:0] dat_next, skid_dat_next;
   logic          stb_next, skid_vld_next, cyc_next;

   function automatic logic [AW-1:0] cp_start(input logic [1:0] sel);
      return AW'(N - (N >> (2 + int'(sel))));
   endfunction

   always_comb begin
      ack        = CYC_I & STB_I & WE_I & ~full[wbuf] & ~RST_I;
      wr_last    = ack & (wptr == LAST);
      pop        = stb & ACK_I;
      occ        = {1'b0, stb} + {1'b0, skid_vld} + {1'b0, rd_vld};
      // Output register + skid hold two samples; a new read must always have a landing slot.
      issue      = (state != RIdle) & ((occ <= 2'd1) | ((occ == 2'd2) & pop));
      rd_last    = issue & (state == RBody) & (rptr == LAST);
      other_full = full[~rbuf] | (wr_last & (wbuf != rbuf));
   end

   always_comb begin
      dat_next      = dat;
      stb_next      = stb;
      skid_dat_next = skid_dat;
      skid_vld_next = skid_vld;
      if (~stb | pop) begin
         if (skid_vld) begin
            dat_next      = skid_dat;
            stb_next      = 1'b1;
            skid_vld_next = rd_vld;
            if (rd_vld) skid_dat_next = rdata;
         end else if (rd_vld) begin
            dat_next = rdata;
            stb_next = 1'b1;
         end else begin
            stb_next = 1'b0;
         end
      end else if (rd_vld) begin
         skid_dat_next = rdata;
         skid_vld_next = 1'b1;
      end
   end

   always_comb begin
      unique case (state)
         RIdle:   busy_next = full[rbuf];
         RCp:     busy_next = 1'b1;
         RBody:   busy_next = ~(rd_last & ~other_full);
         default: busy_next = 1'b0;
      endcase
      // Burst stays open while anything of this or a following symbol is still on its way.
      cyc_next = stb_next | (cyc & (busy_next | issue | skid_vld_next));
   end

   always_ff @(posedge CLK_I) begin
      if (ack) mem[{wbuf, wptr}] <= DAT_I;
      if (issue) rdata <= mem[{rbuf, rptr}];
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         wptr     <= '0;
         wbuf     <= 1'b0;
         rptr     <= '0;
         rbuf     <= 1'b0;
         full     <= '0;
         cp[0]    <= '0;
         cp[1]    <= '0;
         state    <= RIdle;
         rd_vld   <= 1'b0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
         stb      <= 1'b0;
         dat      <= '0;
         cyc      <= 1'b0;
      end else begin
         if (ack) begin
            if (wptr == '0) cp[wbuf] <= CP_SEL;
            if (wr_last) begin
               full[wbuf] <= 1'b1;
               wptr       <= '0;
               wbuf       <= ~wbuf;
            end else begin
               wptr <= wptr + 1'b1;
            end
         end else if (~CYC_I) begin
            wptr <= '0;
         end

         unique case (state)
            RIdle: begin
               if (full[rbuf]) begin
                  state <= RCp;
                  rptr  <= cp_start(cp[rbuf]);
               end
            end
            RCp: begin
               if (issue) begin
                  rptr <= rptr + 1'b1;
                  if (rptr == LAST) state <= RBody;
               end
            end
            RBody: begin
               if (rd_last) begin
                  full[rbuf] <= 1'b0;
                  rbuf       <= ~rbuf;
                  if (other_full) begin
                     state <= RCp;
                     rptr  <= cp_start(cp[~rbuf]);
                  end else begin
                     state <= RIdle;
                     rptr  <= '0;
                  end
               end else if (issue) begin
                  rptr <= rptr + 1'b1;
               end
            end
            default: state <= RIdle;
         endcase

         rd_vld   <= issue;
         skid_vld <= skid_vld_next;
         skid_dat <= skid_dat_next;
         stb      <= stb_next;
         dat      <= dat_next;
         cyc      <= cyc_next;
      end
   end

   assign ACK_O = ack;
   assign DAT_O = dat;
   assign STB_O = stb;
   assign WE_O  = stb;
   assign CYC_O = cyc;

endmodule

// File: tb/tb_cp_insert_param.sv
// Randomised bench for cp_insert_param: a symbol-level model turns every accepted input
// symbol into its expected CP + body sequence and checks each output transfer against it.
module tb_cp_insert_param;

   localparam int N  = 256;
   localparam int DW = 32;

   logic          clk, rst;
   logic [DW-1:0] dat_i, dat_o;
   logic          cyc_i, stb_i, we_i, ack_o;
   logic [1:0]    cp_sel;
   logic          cyc_o, stb_o, we_o, ack_i;

   cp_insert_param #(.NFFT_LOG2(8), .DW(DW)) dut (
      .CLK_I (clk),
      .RST_I (rst),
      .DAT_I (dat_i),
      .CYC_I (cyc_i),
      .STB_I (stb_i),
      .WE_I  (we_i),
      .ACK_O (ack_o),
      .CP_SEL(cp_sel),
      .DAT_O (dat_o),
      .CYC_O (cyc_o),
      .STB_O (stb_o),
      .WE_O  (we_o),
      .ACK_I (ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input longint got_v, input longint exp_v);
      compared++;
      if (got_v != exp_v) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, got_v, exp_v);
      end
   endtask

   // Model state
   logic [DW-1:0] cur[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got[$];
   int            wcnt = 0;
   logic [1:0]    cur_cp = 2'd0;
   int            cyc_n = 0;
   int            stalls = 0;
   bit            prev_hold = 1'b0;
   logic [DW-1:0] prev_dat = '0;
   bit            lat_arm = 1'b0;
   int            done_cyc = -1;
   int            stb_cyc = -1;
   bit            cont_arm = 1'b0;
   int            cont_total = 0;
   bit            ack_rand = 1'b0;

   always @(negedge clk) begin
      cyc_n++;
      chk("we_eq_stb", we_o, stb_o);
      if (rst) begin
         chk("ack_in_reset", ack_o, 0);
         cur.delete();
         exp_q.delete();
         wcnt = 0;
         prev_hold = 1'b0;
      end else begin
         if (ack_o) begin
            chk("ack_legal", cyc_i & stb_i & we_i, 1);
            if (wcnt == 0) cur_cp = cp_sel;
            cur.push_back(dat_i);
            wcnt++;
            if (wcnt == N) begin
               int ncp;
               ncp = N >> (2 + int'(cur_cp));
               for (int i = N - ncp; i < N; i++) exp_q.push_back(cur[i]);
               for (int i = 0; i < N; i++) exp_q.push_back(cur[i]);
               cur.delete();
               wcnt = 0;
               if (lat_arm && done_cyc < 0) done_cyc = cyc_n;
            end
         end else if (!cyc_i && wcnt > 0) begin
            cur.delete();
            wcnt = 0;
         end
         if (cyc_i & stb_i & we_i & ~ack_o) stalls++;
         if (prev_hold) begin
            chk("hold_stb", stb_o, 1);
            chk("hold_dat", dat_o, prev_dat);
         end
         if (stb_o) chk("cyc_with_stb", cyc_o, 1);
         if (lat_arm && stb_o && stb_cyc < 0) stb_cyc = cyc_n;
         if (cont_arm && got.size() > 0 && got.size() < cont_total)
            chk("stb_continuous", stb_o, 1);
         if (stb_o && ack_i) begin
            got.push_back(dat_o);
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_output: got %0d, required no output", dat_o);
            end else begin
               chk("data", dat_o, exp_q.pop_front());
            end
         end
         prev_hold = stb_o & ~ack_i;
         prev_dat  = dat_o;
      end
   end

   initial begin
      ack_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ack_i = ack_rand ? ($urandom_range(1) == 1) : 1'b1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   task automatic send_sym(input int base, input int sel, input int n, input bit gaps);
      bit acked;
      int waitc;
      cp_sel = 2'(sel);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(3) == 0) begin
            cyc_i = 1'b1;
            stb_i = 1'b0;
            @(posedge clk);
            #1;
         end
         // Mid-symbol CP changes must not affect the symbol in progress.
         if (k == 40) cp_sel = ~cp_sel;
         cyc_i = 1'b1;
         stb_i = 1'b1;
         we_i  = 1'b1;
         dat_i = DW'(base + k);
         acked = 1'b0;
         waitc = 0;
         while (!acked && waitc < 4000) begin
            @(negedge clk);
            acked = ack_o;
            waitc++;
            @(posedge clk);
            #1;
         end
         if (!acked) begin
            chk("ack_timeout", 0, 1);
            stb_i = 1'b0;
            return;
         end
      end
      stb_i = 1'b0;
      if (n < N) begin
         cyc_i = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || stb_o) && n < 6000);
      chk("drain_pending", exp_q.size(), 0);
      chk("cyc_idle_after_drain", cyc_o, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_got(input string name, input int idx, input longint exp_v);
      if (idx < got.size()) chk(name, got[idx], exp_v);
      else chk(name, -1, exp_v);
   endtask

   initial begin
      int base;
      rst = 1'b1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i = 1'b1;
      dat_i = '0;
      cp_sel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stb", stb_o, 0);
      chk("rst_cyc", cyc_o, 0);
      chk("rst_we", we_o, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_ack", ack_o, 0);
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // CP 1/4, k = 0..255
      got.delete();
      lat_arm = 1'b1;
      send_sym(0, 0, N, 1'b0);
      drain();
      lat_arm = 1'b0;
      chk("t1_count", got.size(), 320);
      chk_got("t1_first", 0, 192);
      chk_got("t1_cp_last", 63, 255);
      chk_got("t1_body_first", 64, 0);
      chk_got("t1_last", 319, 255);
      // Last write in cycle c, R_CP entered at end of c+1, STB_O rises two edges later.
      chk("t1_stb_latency", stb_cyc - done_cyc, 4);

      // CP 1/32 then 1/8
      got.delete();
      send_sym(0, 3, N, 1'b0);
      send_sym(0, 1, N, 1'b0);
      drain();
      chk("t2_count", got.size(), 552);
      chk_got("t2_first", 0, 248);
      chk_got("t2_body0", 8, 0);
      chk_got("t2_sym2_first", 264, 224);
      chk_got("t2_sym2_body0", 296, 0);

      // Four back-to-back symbols
      got.delete();
      stalls = 0;
      cont_arm = 1'b1;
      cont_total = 4 * 320;
      for (int s = 0; s < 4; s++) send_sym(s * N, 0, N, 1'b0);
      drain();
      cont_arm = 1'b0;
      chk("t3_count", got.size(), 1280);
      chk("t3_backpressure", stalls > 0, 1);
      chk_got("t3_sym2_first", 320, 448);
      chk_got("t3_sym4_first", 960, 960);

      // Random downstream ACK
      got.delete();
      ack_rand = 1'b1;
      send_sym(0, 0, N, 1'b0);
      send_sym(N, 0, N, 1'b0);
      drain();
      ack_rand = 1'b0;
      chk("t4_count", got.size(), 640);
      chk_got("t4_first", 0, 192);
      chk_got("t4_sym2_first", 320, 448);
      chk_got("t4_last", 639, 511);

      // Aborted partial symbol followed by a full one
      got.delete();
      send_sym(0, 0, 100, 1'b0);
      send_sym(1000, 0, N, 1'b0);
      drain();
      chk("t5_count", got.size(), 320);
      chk_got("t5_first", 0, 1192);
      chk_got("t5_body0", 64, 1000);

      // Reset during body readout with the other buffer also full
      got.delete();
      send_sym(2000, 0, N, 1'b0);
      send_sym(3000, 0, N, 1'b0);
      chk("t6_in_body", (got.size() > 64) && (got.size() < 320), 1);
      rst = 1'b1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i = 1'b1;
      #1;
      chk("t6_ack_during_rst", ack_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stb_i = 1'b0;
      chk("t6_stb_after_rst", stb_o, 0);
      chk("t6_cyc_after_rst", cyc_o, 0);
      chk("t6_ack_after_rst", ack_o, 0);
      got.delete();
      send_sym(4000, 2, N, 1'b0);
      drain();
      chk("t6_count", got.size(), 272);
      chk_got("t6_first", 0, 4240);
      chk_got("t6_body0", 16, 4000);
      chk_got("t6_last", 271, 4255);

      // Random CP, input gaps, aborts and downstream ACK
      got.delete();
      ack_rand = 1'b1;
      base = 10000;
      for (int s = 0; s < 6; s++) begin
         if ($urandom_range(3) == 0) send_sym(base + 5000, $urandom_range(3),
                                              $urandom_range(255, 1), 1'b1);
         send_sym(base, $urandom_range(3), N, 1'b1);
         base += 1000;
      end
      drain();
      ack_rand = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
